// File: rtl/hazard_halt_unit_pkg.sv
// Shared definitions for the hazard/halt sequencing block: FSM encodings and
// the default register-address width.
package hazard_halt_unit_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_DRAIN  = 2'b01,
    ST_HALTED = 2'b10
  } hh_state_t;

  localparam int REG_ADDR_W_DEF = 5;

endpackage

// File: rtl/hazard_halt_unit_load_use_detector.sv
// Combinational load-use compare between the EX-stage load destination and
// the source registers of the instruction sitting in ID.
module load_use_detector
  import hazard_halt_unit_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic                  i_ex_mem_read,
  input  logic [REG_ADDR_W-1:0] i_ex_rt_dst,
  input  logic [REG_ADDR_W-1:0] i_id_rs,
  input  logic [REG_ADDR_W-1:0] i_id_rt,
  input  logic                  i_id_uses_rt,
  output logic                  o_lu
);

  logic dst_nonzero;
  logic rs_match;
  logic rt_match;

  // Register 0 is hardwired, so a load targeting it never creates a dependency.
  assign dst_nonzero = |i_ex_rt_dst;
  assign rs_match    = (i_ex_rt_dst == i_id_rs);
  assign rt_match    = i_id_uses_rt && (i_ex_rt_dst == i_id_rt);
  assign o_lu        = i_ex_mem_read && dst_nonzero && (rs_match || rt_match);

endmodule

// File: rtl/hazard_halt_unit.sv
// Load-use bubble insertion, HALT drain sequencing and debug single-step
// gating for the in-order pipeline; feeds the control unit's hazard/halt inputs.
module hazard_halt_unit
  import hazard_halt_unit_pkg::*;
#(
  parameter int REG_ADDR_W   = REG_ADDR_W_DEF,
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [REG_ADDR_W-1:0] i_id_rs,
  input  logic [REG_ADDR_W-1:0] i_id_rt,
  input  logic                  i_id_uses_rt,
  input  logic                  i_id_halt,
  input  logic                  i_ex_mem_read,
  input  logic [REG_ADDR_W-1:0] i_ex_rt_dst,
  input  logic                  i_dbg_mode,
  input  logic                  i_dbg_step,
  output logic                  o_hazard_detected,
  output logic                  o_flg_halt,
  output logic                  o_pc_stall,
  output logic                  o_if_id_stall,
  output logic                  o_pipe_en,
  output logic                  o_halted,
  output logic [CNT_W-1:0]      o_cycle_count
);

  localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_CYCLES - 1);

  hh_state_t      state;
  logic [DCW-1:0] drain_cnt;
  logic           lu;
  logic           in_run;
  logic           lu_run;
  logic           halt_det;
  logic           holding;
  logic           pipe_en;

  load_use_detector #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_lu (
    .i_ex_mem_read (i_ex_mem_read),
    .i_ex_rt_dst   (i_ex_rt_dst),
    .i_id_rs       (i_id_rs),
    .i_id_rt       (i_id_rt),
    .i_id_uses_rt  (i_id_uses_rt),
    .o_lu          (lu)
  );

  assign in_run   = (state == ST_RUN);
  assign lu_run   = in_run && lu;
  // A pending load-use hazard defers HALT recognition to a later cycle.
  assign halt_det = in_run && i_id_halt && !lu;
  assign holding  = (state == ST_DRAIN) || (state == ST_HALTED);
  assign pipe_en  = (state != ST_HALTED) && (!i_dbg_mode || i_dbg_step);

  assign o_hazard_detected = lu_run;
  assign o_flg_halt        = halt_det || holding;
  assign o_pc_stall        = lu_run || halt_det || holding;
  assign o_if_id_stall     = lu_run || halt_det || holding;
  assign o_pipe_en         = pipe_en;
  assign o_halted          = (state == ST_HALTED);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= ST_RUN;
      drain_cnt <= '0;
    end else begin
      unique case (state)
        ST_RUN: begin
          if (halt_det && pipe_en) begin
            state     <= ST_DRAIN;
            drain_cnt <= '0;
          end
        end
        ST_DRAIN: begin
          // Only enabled cycles move EX/MEM/WB forward, so only they count.
          if (pipe_en) begin
            if (drain_cnt == DRAIN_LAST) begin
              state <= ST_HALTED;
            end else begin
              drain_cnt <= drain_cnt + 1'b1;
            end
          end
        end
        ST_HALTED: begin
          state <= ST_HALTED;
        end
        default: begin
          state     <= ST_RUN;
          drain_cnt <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_cycle_count <= '0;
    end else if (pipe_en && (o_cycle_count != {CNT_W{1'b1}})) begin
      o_cycle_count <= o_cycle_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_halt_unit.sv
// Directed bench for hazard_halt_unit: load-use, HALT drain, single-step,
// priority and asynchronous reset behaviour with hand-computed expectations.
module tb_hazard_halt_unit;

  localparam int REG_ADDR_W   = 5;
  localparam int DRAIN_CYCLES = 3;
  localparam int CNT_W        = 32;

  logic                  clk;
  logic                  rst_n;
  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;
  logic                  id_uses_rt;
  logic                  id_halt;
  logic                  ex_mem_read;
  logic [REG_ADDR_W-1:0] ex_rt_dst;
  logic                  dbg_mode;
  logic                  dbg_step;
  logic                  hazard_detected;
  logic                  flg_halt;
  logic                  pc_stall;
  logic                  if_id_stall;
  logic                  pipe_en;
  logic                  halted;
  logic [CNT_W-1:0]      cycle_count;

  int checks;
  int errors;

  hazard_halt_unit #(
    .REG_ADDR_W   (REG_ADDR_W),
    .DRAIN_CYCLES (DRAIN_CYCLES),
    .CNT_W        (CNT_W)
  ) dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .i_id_rs           (id_rs),
    .i_id_rt           (id_rt),
    .i_id_uses_rt      (id_uses_rt),
    .i_id_halt         (id_halt),
    .i_ex_mem_read     (ex_mem_read),
    .i_ex_rt_dst       (ex_rt_dst),
    .i_dbg_mode        (dbg_mode),
    .i_dbg_step        (dbg_step),
    .o_hazard_detected (hazard_detected),
    .o_flg_halt        (flg_halt),
    .o_pc_stall        (pc_stall),
    .o_if_id_stall     (if_id_stall),
    .o_pipe_en         (pipe_en),
    .o_halted          (halted),
    .o_cycle_count     (cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    id_rs = '0; id_rt = '0; id_uses_rt = 1'b0; id_halt = 1'b0;
    ex_mem_read = 1'b0; ex_rt_dst = '0; dbg_mode = 1'b0; dbg_step = 1'b0;
  endtask

  // Pass n rising edges and return at the following falling edge.
  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    @(negedge clk);
  endtask

  // Reset asserted between edges, released on a falling edge.
  task automatic do_reset(input logic mode);
    @(negedge clk);
    #2 rst_n = 1'b0;
    clear_inputs();
    dbg_mode = mode;
    cycles(2);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    do_reset(1'b0);
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b want 0", halted); end
    checks++; if (cycle_count !== 32'd0) begin errors++; $display("FAIL reset_count got %0d want 0", cycle_count); end
    checks++; if ({hazard_detected, flg_halt, pc_stall, if_id_stall} !== 4'b0000) begin errors++; $display("FAIL reset_comb got %b want 0000", {hazard_detected, flg_halt, pc_stall, if_id_stall}); end
    checks++; if (pipe_en !== 1'b1) begin errors++; $display("FAIL reset_pipe_en got %b want 1", pipe_en); end
    cycles(4);
    checks++; if (cycle_count !== 32'd4) begin errors++; $display("FAIL free_count got %0d want 4", cycle_count); end
  endtask

  task automatic test_load_use();
    ex_mem_read = 1'b1; ex_rt_dst = 5'd5; id_rs = 5'd5; #1;
    checks++; if ({hazard_detected, pc_stall, if_id_stall, flg_halt} !== 4'b1110) begin errors++; $display("FAIL lu_rs got %b want 1110", {hazard_detected, pc_stall, if_id_stall, flg_halt}); end
    ex_rt_dst = 5'd0; id_rs = 5'd0; #1;
    checks++; if ({hazard_detected, pc_stall, if_id_stall} !== 3'b000) begin errors++; $display("FAIL lu_r0 got %b want 000", {hazard_detected, pc_stall, if_id_stall}); end
    ex_mem_read = 1'b0; ex_rt_dst = 5'd9; id_rs = 5'd9; #1;
    checks++; if (hazard_detected !== 1'b0) begin errors++; $display("FAIL lu_noload got %b want 0", hazard_detected); end
    clear_inputs(); #1;
  endtask

  task automatic test_rt_sensitivity();
    ex_mem_read = 1'b1; ex_rt_dst = 5'd7; id_rt = 5'd7; id_rs = 5'd3; id_uses_rt = 1'b0; #1;
    checks++; if ({hazard_detected, pc_stall} !== 2'b00) begin errors++; $display("FAIL rt_unused got %b want 00", {hazard_detected, pc_stall}); end
    id_uses_rt = 1'b1; #1;
    checks++; if ({hazard_detected, pc_stall, if_id_stall} !== 3'b111) begin errors++; $display("FAIL rt_used got %b want 111", {hazard_detected, pc_stall, if_id_stall}); end
    clear_inputs(); #1;
  endtask

  task automatic test_halt_free_run();
    do_reset(1'b0);
    cycles(2);
    id_halt = 1'b1; #1;
    checks++; if ({flg_halt, pc_stall, if_id_stall, hazard_detected} !== 4'b1110) begin errors++; $display("FAIL halt_detect got %b want 1110", {flg_halt, pc_stall, if_id_stall, hazard_detected}); end
    cycles(1);
    id_halt = 1'b0; #1;
    checks++; if ({flg_halt, pc_stall, halted} !== 3'b110) begin errors++; $display("FAIL halt_drain1 got %b want 110", {flg_halt, pc_stall, halted}); end
    cycles(2);
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_early got %b want 0", halted); end
    cycles(1);
    checks++; if ({halted, pipe_en, flg_halt, if_id_stall} !== 4'b1011) begin errors++; $display("FAIL halt_done got %b want 1011", {halted, pipe_en, flg_halt, if_id_stall}); end
    checks++; if (cycle_count !== 32'd6) begin errors++; $display("FAIL halt_count got %0d want 6", cycle_count); end
    ex_mem_read = 1'b1; ex_rt_dst = 5'd4; id_rs = 5'd4;
    cycles(5);
    checks++; if (cycle_count !== 32'd6 || halted !== 1'b1 || hazard_detected !== 1'b0) begin errors++; $display("FAIL halt_frozen got cnt=%0d halted=%b haz=%b want 6 1 0", cycle_count, halted, hazard_detected); end
    #2 rst_n = 1'b0; #1;
    checks++; if (halted !== 1'b0 || cycle_count !== 32'd0 || flg_halt !== 1'b0) begin errors++; $display("FAIL halted_async_rst got halted=%b cnt=%0d flg=%b want 0 0 0", halted, cycle_count, flg_halt); end
    rst_n = 1'b1;
    clear_inputs();
  endtask

  task automatic step_pulse();
    dbg_step = 1'b1;
    cycles(1);
    dbg_step = 1'b0;
  endtask

  task automatic test_single_step();
    do_reset(1'b1);
    checks++; if (pipe_en !== 1'b0) begin errors++; $display("FAIL step_idle_en got %b want 0", pipe_en); end
    cycles(10);
    checks++; if (cycle_count !== 32'd0) begin errors++; $display("FAIL step_idle_count got %0d want 0", cycle_count); end
    for (int s = 0; s < 3; s++) begin
      step_pulse();
      cycles(2);
    end
    checks++; if (cycle_count !== 32'd3) begin errors++; $display("FAIL step_count got %0d want 3", cycle_count); end
    id_halt = 1'b1; #1;
    checks++; if (flg_halt !== 1'b1) begin errors++; $display("FAIL step_halt_flag got %b want 1", flg_halt); end
    cycles(2);
    id_halt = 1'b0; #1;
    checks++; if (flg_halt !== 1'b0) begin errors++; $display("FAIL step_halt_unstepped got %b want 0", flg_halt); end
    id_halt = 1'b1;
    step_pulse();
    id_halt = 1'b0;
    for (int s = 0; s < 2; s++) begin
      cycles(3);
      step_pulse();
    end
    checks++; if ({halted, flg_halt} !== 2'b01) begin errors++; $display("FAIL step_drain_mid got %b want 01", {halted, flg_halt}); end
    cycles(3);
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL step_drain_wait got %b want 0", halted); end
    step_pulse();
    checks++; if (halted !== 1'b1 || cycle_count !== 32'd7) begin errors++; $display("FAIL step_halted got halted=%b cnt=%0d want 1 7", halted, cycle_count); end
    dbg_step = 1'b1; #1;
    checks++; if (pipe_en !== 1'b0) begin errors++; $display("FAIL step_halted_en got %b want 0", pipe_en); end
    dbg_step = 1'b0;
  endtask

  task automatic test_simultaneous();
    do_reset(1'b0);
    ex_mem_read = 1'b1; ex_rt_dst = 5'd12; id_rs = 5'd12; id_halt = 1'b1; #1;
    checks++; if ({hazard_detected, flg_halt, pc_stall, if_id_stall} !== 4'b1011) begin errors++; $display("FAIL sim_both got %b want 1011", {hazard_detected, flg_halt, pc_stall, if_id_stall}); end
    cycles(1);
    id_halt = 1'b0; #1;
    checks++; if ({hazard_detected, flg_halt} !== 2'b10) begin errors++; $display("FAIL sim_still_run got %b want 10", {hazard_detected, flg_halt}); end
    ex_mem_read = 1'b0; id_halt = 1'b1; #1;
    checks++; if ({hazard_detected, flg_halt} !== 2'b01) begin errors++; $display("FAIL sim_halt_taken got %b want 01", {hazard_detected, flg_halt}); end
    cycles(1);
    id_halt = 1'b0; #1;
    checks++; if ({flg_halt, halted} !== 2'b10) begin errors++; $display("FAIL sim_drain got %b want 10", {flg_halt, halted}); end
  endtask

  task automatic test_reset_mid_drain();
    cycles(1);
    checks++; if (cycle_count !== 32'd3) begin errors++; $display("FAIL drain_count got %0d want 3", cycle_count); end
    #2 rst_n = 1'b0; #1;
    checks++; if (halted !== 1'b0 || cycle_count !== 32'd0 || flg_halt !== 1'b0 || pc_stall !== 1'b0) begin errors++; $display("FAIL drain_async_rst got halted=%b cnt=%0d flg=%b stall=%b want 0 0 0 0", halted, cycle_count, flg_halt, pc_stall); end
    cycles(1);
    rst_n = 1'b1;
    cycles(DRAIN_CYCLES + 1);
    checks++; if (halted !== 1'b0 || cycle_count !== 32'd4) begin errors++; $display("FAIL drain_rst_run got halted=%b cnt=%0d want 0 4", halted, cycle_count); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b1;
    clear_inputs();
    test_reset();
    test_load_use();
    test_rt_sensitivity();
    test_halt_free_run();
    test_single_step();
    test_simultaneous();
    test_reset_mid_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_halt_unit.md
# hazard_halt_unit

Pipeline-sequencing block feeding the control unit's `i_hazard_detected` and `i_flg_halt` inputs. It also drives the PC and IF/ID stall enables and the global pipeline-register enable.

- Detects load-use hazards between the ID and EX stages and inserts one bubble per hazard.
- Recognises a decoded HALT, freezes fetch, and drains older instructions through EX/MEM/WB before reporting halted.
- Gates the pipeline for debug single-stepping.

It sits beside the decode stage and is the producer side of the hazard/halt interface that the control unit consumes.

## Interface
Parameters:
- `REG_ADDR_W`, default 5: register-address width.
- `DRAIN_CYCLES`, default 3: enabled cycles needed to retire EX, MEM and WB after HALT.
- `CNT_W`, default 32: cycle-counter width.

Ports (one clock; reset is asynchronous and active-low):
- `i_clk`  in  1  system clock.
- `i_rst_n`  in  1  asynchronous active-low reset.
- `i_id_rs`  in  REG_ADDR_W  rs field of the instruction in ID.
- `i_id_rt`  in  REG_ADDR_W  rt field of the instruction in ID.
- `i_id_uses_rt`  in  1  1 when the ID instruction reads rt as a source.
- `i_id_halt`  in  1  ID instruction is HALT.
- `i_ex_mem_read`  in  1  EX instruction is a load.
- `i_ex_rt_dst`  in  REG_ADDR_W  destination register of the EX load.
- `i_dbg_mode`  in  1  1 selects single-step mode.
- `i_dbg_step`  in  1  one-cycle step pulse from the debug unit.
- `o_hazard_detected`  out  1  to the control unit; kills the ID instruction's writes (bubble).
- `o_flg_halt`  out  1  to the control unit; kills the writes of the HALT instruction in ID.
- `o_pc_stall`  out  1  holds the PC.
- `o_if_id_stall`  out  1  holds the IF/ID register.
- `o_pipe_en`  out  1  global pipeline-register enable.
- `o_halted`  out  1  drain complete.
- `o_cycle_count`  out  CNT_W  number of executed (enabled) cycles.

## Operation
- FSM states: RUN, DRAIN, HALTED.
- `o_pipe_en` is 0 in HALTED. Otherwise it is `~i_dbg_mode | i_dbg_step`.
- Load-use hazard (RUN only). `lu` is true when all of the following hold:
  - `i_ex_mem_read` = 1;
  - `i_ex_rt_dst` ≠ 0;
  - `i_ex_rt_dst` equals `i_id_rs`, or (`i_id_uses_rt` = 1 and `i_ex_rt_dst` equals `i_id_rt`).
- When `lu` is true: `o_hazard_detected` = `o_pc_stall` = `o_if_id_stall` = 1, combinational in the same cycle.
- HALT handling:
  - In RUN, `i_id_halt` with `lu` = 0 drives `o_flg_halt` = `o_pc_stall` = `o_if_id_stall` = 1 in the same cycle.
  - If that cycle has `o_pipe_en` = 1, the next state is DRAIN and the drain counter loads 0.
- DRAIN:
  - `o_flg_halt`, `o_pc_stall` and `o_if_id_stall` are held at 1, so the HALT sits in ID and its copies entering EX are write-killed.
  - The counter increments only on cycles with `o_pipe_en` = 1.
  - When it reaches `DRAIN_CYCLES` - 1 on an enabled cycle, the next state is HALTED.
- HALTED:
  - Terminal until reset.
  - `o_halted` = 1, `o_pipe_en` = 0, stalls = 1, `o_flg_halt` = 1.
- Priority: a load-use hazard wins over HALT in RUN, and HALT is taken on a later cycle. Step gating applies on top of everything.
- `o_cycle_count` increments on every cycle with `o_pipe_en` = 1 and state ≠ HALTED. It saturates at all-ones.

## Timing
- Hazard, stall and `o_flg_halt` outputs are combinational from inputs and state: 0-cycle latency.
- `o_halted` is decoded from the registered state. It asserts exactly `DRAIN_CYCLES` + 1 enabled cycles after the HALT-detect cycle.
- A stalled RUN cycle (`o_pipe_en` = 0 in step mode) does not advance the FSM. The combinational hazard/halt outputs still reflect their inputs.
- `i_dbg_step` while `i_dbg_mode` = 0 has no effect.
- Reset values: state RUN, drain counter 0, `o_cycle_count` 0, `o_halted` 0. All combinational outputs evaluate from RUN.
- Reset asserted mid-DRAIN or in HALTED returns to RUN immediately (asynchronously) and clears the counters.

## Structure
- Shared package/header holds:
  - state encodings RUN = 2'b00, DRAIN = 2'b01, HALTED = 2'b10;
  - the `REG_ADDR_W` default.
- One sub-module is natural: `load_use_detector`, the purely combinational `lu` compare. The FSM and counters stay in the top level.

## Test plan
- Load-use: EX load with `i_ex_rt_dst` = 5, `i_id_rs` = 5 -> `o_hazard_detected` = `o_pc_stall` = `o_if_id_stall` = 1 in that cycle. With `i_ex_rt_dst` = 0 -> all three are 0.
- rt sensitivity: `i_ex_rt_dst` = 7, `i_id_rt` = 7, `i_id_uses_rt` = 0 -> no hazard. Same with `i_id_uses_rt` = 1 -> hazard.
- HALT in free-run: `i_id_halt` pulse at cycle N -> `o_flg_halt` = 1 from N. `o_halted` rises at N + 4 (`DRAIN_CYCLES` = 3). `o_pipe_en` = 0 afterwards. `o_cycle_count` frozen.
- Single-step: `i_dbg_mode` = 1, no steps for 10 cycles -> count unchanged. 3 step pulses -> count +3. HALT drain needs 3 steps after detect, plus the detect step itself.
- Simultaneous load-use and HALT: both true -> hazard asserted, state stays RUN. Next cycle with the hazard cleared -> DRAIN.
- Reset mid-DRAIN: assert `i_rst_n` = 0 asynchronously -> state RUN, `o_halted` = 0, `o_cycle_count` = 0 without waiting for a clock edge.
